// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan engine for a 1/16-scan panel. It shifts the next row while the previously
// latched row is lit, then blanks, latches and advances the row address.
module hub75_scan_ctrl #(
  parameter int unsigned COLS         = 64,
  parameter int unsigned ROWS         = 16,
  parameter int unsigned ON_CYCLES    = 256,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [6:0] col,
  output logic [3:0] row,
  input  logic       r0,
  input  logic       g0,
  input  logic       b0,
  input  logic       r1,
  input  logic       g1,
  input  logic       b1,
  output logic       p_r0,
  output logic       p_g0,
  output logic       p_b0,
  output logic       p_r1,
  output logic       p_g1,
  output logic       p_b1,
  output logic       p_clk,
  output logic       p_lat,
  output logic       p_oe_n,
  output logic [3:0] p_addr,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned ON_W  = $clog2(ON_CYCLES + 1);
  localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [ON_W-1:0]  ON_MAX   = ON_W'(ON_CYCLES);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [6:0]       COL_LAST = 7'(COLS - 1);
  localparam logic [3:0]       ROW_LAST = 4'(ROWS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_BLANK = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             ph_q, ph_d;
  logic             last_q, last_d;
  logic [6:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic             lit_q, lit_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [5:0]       data_q, data_d;
  logic             p_clk_q, p_clk_d;
  logic             p_lat_q, p_lat_d;
  logic             p_oe_n_q, p_oe_n_d;
  logic [3:0]       addr_q, addr_d;
  logic             fd_q, fd_d;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    last_d   = last_q;
    col_d    = col_q;
    row_d    = row_q;
    lit_d    = lit_q;
    blk_d    = blk_q;
    data_d   = data_q;
    p_clk_d  = 1'b0;
    p_lat_d  = 1'b0;
    addr_d   = addr_q;
    fd_d     = 1'b0;
    // Lighting timer restarts when a new row is latched and saturates at ON_MAX.
    if (state_q == S_LATCH) begin
      on_cnt_d = '0;
    end else if (on_cnt_q < ON_MAX) begin
      on_cnt_d = on_cnt_q + ON_W'(1);
    end else begin
      on_cnt_d = on_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        col_d = '0;
        ph_d  = 1'b0;
        if (en) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!ph_q) begin
          data_d = {r0, g0, b0, r1, g1, b1};
          col_d  = col_q + 7'd1;
          last_d = (col_q == COL_LAST);
          ph_d   = 1'b1;
        end else begin
          p_clk_d = 1'b1;
          ph_d    = 1'b0;
          if (last_q) begin
            col_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!lit_q || on_cnt_q >= ON_MAX) begin
          state_d = S_BLANK;
          blk_d   = '0;
        end
      end
      S_BLANK: begin
        if (blk_q == BLK_LAST) begin
          state_d = S_LATCH;
          p_lat_d = 1'b1;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      S_LATCH: begin
        addr_d  = row_q;
        row_d   = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
        fd_d    = (row_q == ROW_LAST);
        lit_d   = 1'b1;
        state_d = en ? S_SHIFT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Output enable is decoded from next-state values so the pin is a plain register.
    p_oe_n_d = !(lit_d && (on_cnt_d < ON_MAX) && (state_d == S_SHIFT || state_d == S_WAIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      last_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      on_cnt_q <= '0;
      lit_q    <= 1'b0;
      blk_q    <= '0;
      data_q   <= '0;
      p_clk_q  <= 1'b0;
      p_lat_q  <= 1'b0;
      p_oe_n_q <= 1'b1;
      addr_q   <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      last_q   <= last_d;
      col_q    <= col_d;
      row_q    <= row_d;
      on_cnt_q <= on_cnt_d;
      lit_q    <= lit_d;
      blk_q    <= blk_d;
      data_q   <= data_d;
      p_clk_q  <= p_clk_d;
      p_lat_q  <= p_lat_d;
      p_oe_n_q <= p_oe_n_d;
      addr_q   <= addr_d;
      fd_q     <= fd_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} = data_q;
  assign p_clk      = p_clk_q;
  assign p_lat      = p_lat_q;
  assign p_oe_n     = p_oe_n_q;
  assign p_addr     = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: random image served as the data driver, per-row timing table,
// en drop mid-row and asynchronous reset mid-shift.
module tb_hub75_scan_ctrl;

  localparam int C  = 64;
  localparam int R  = 16;
  localparam int ON = 256;
  localparam int B  = 2;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [6:0] col;
  logic [3:0] row;
  logic       r0, g0, b0, r1, g1, b1;
  logic       p_r0, p_g0, p_b0, p_r1, p_g1, p_b1;
  logic       p_clk, p_lat, p_oe_n;
  logic [3:0] p_addr;
  logic       busy, frame_done;

  hub75_scan_ctrl #(
    .COLS(C), .ROWS(R), .ON_CYCLES(ON), .BLANK_CYCLES(B)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .col(col), .row(row),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .p_r0(p_r0), .p_g0(p_g0), .p_b0(p_b0), .p_r1(p_r1), .p_g1(p_g1), .p_b1(p_b1),
    .p_clk(p_clk), .p_lat(p_lat), .p_oe_n(p_oe_n), .p_addr(p_addr),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [5:0] img [R][C];

  always_comb begin
    {r0, g0, b0, r1, g1, b1} = 6'd0;
    if (int'(col) < C) {r0, g0, b0, r1, g1, b1} = img[row][col];
  end

  typedef struct {
    bit from_idle;
    bit drop_en;
    bit do_reset;
    int exp_addr;
    bit exp_fd;
    int exp_gap;
    int exp_oe;
  } vec_t;

  vec_t vecs[26];

  int tests = 0, fails = 0;
  int edge_cnt = 0, pix_err = 0, shift_row = 0, oe_low = 0, viol = 0, fd_cnt = 0;
  int gap, n, idle_viol, fd_exp;
  bit prev_pclk = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Advance one clock and sample away from the edge, updating the panel-side monitors.
  task automatic step();
    @(posedge clk);
    #1;
    if (p_clk && !prev_pclk) begin
      if (edge_cnt < C && {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} !== img[shift_row][edge_cnt])
        pix_err++;
      edge_cnt++;
    end
    prev_pclk = p_clk;
    if (!p_oe_n) oe_low++;
    if (p_lat && (p_clk || !p_oe_n)) viol++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_col"}, col, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_pdata"}, {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1}, 0);
    check({tag, "_p_clk"}, p_clk, 0);
    check({tag, "_p_lat"}, p_lat, 0);
    check({tag, "_p_oe_n"}, p_oe_n, 1);
    check({tag, "_p_addr"}, p_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int gap_cold, gap_lit, wait_lit;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = 6'($urandom);

    // Row period arithmetic: shift 2*C cycles, wait until the lit row has had ON cycles,
    // blank B cycles, latch 1 cycle.
    wait_lit = (ON > 2 * C) ? ON - 2 * C + 1 : 1;
    gap_cold = 2 * C + 1 + B;
    gap_lit  = 1 + 2 * C + wait_lit + B;
    fd_exp   = 0;
    for (int i = 0; i < 24; i++) begin
      vecs[i] = '{from_idle: (i == 0), drop_en: (i == 23), do_reset: 1'b0,
                  exp_addr: i % R, exp_fd: (i % R == R - 1),
                  exp_gap: (i == 0) ? gap_cold : gap_lit, exp_oe: (i == 0) ? 0 : ON};
    end
    vecs[24] = '{from_idle: 1'b1, drop_en: 1'b0, do_reset: 1'b0, exp_addr: 8, exp_fd: 1'b0,
                 exp_gap: gap_cold, exp_oe: 0};
    vecs[25] = '{from_idle: 1'b1, drop_en: 1'b0, do_reset: 1'b1, exp_addr: 0, exp_fd: 1'b0,
                 exp_gap: gap_cold, exp_oe: 0};
    foreach (vecs[i]) if (vecs[i].exp_fd) fd_exp++;

    rst = 1'b0;
    en  = 1'b0;
    #2 rst = 1'b1;
    repeat (3) step();
    check_reset("rst");
    rst = 1'b0;
    idle_viol = 0;
    repeat (20) begin
      step();
      if (busy || !p_oe_n || p_clk || col != 7'd0) idle_viol++;
    end
    check("idle_en0", idle_viol, 0);

    for (int i = 0; i < 26; i++) begin
      if (vecs[i].do_reset) begin
        n = 0;
        while (col != 7'd30 && n < 500) begin
          step();
          n++;
        end
        check("reach_col30", col, 30);
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        repeat (2) step();
        prev_pclk = 1'b0;
        edge_cnt  = 0;
        pix_err   = 0;
        shift_row = 0;
        rst       = 1'b0;
      end
      if (vecs[i].from_idle) begin
        oe_low = 0;
        en     = 1'b1;
        n      = 0;
        while (!busy && n < 50) begin
          step();
          n++;
        end
        check("start_busy", busy, 1);
        gap = 0;
      end
      while (!p_lat && gap < 2000) begin
        step();
        gap++;
        if (vecs[i].drop_en && gap == 40) en = 1'b0;
      end
      check("lat_gap", gap, vecs[i].exp_gap);
      check("oe_low", oe_low, vecs[i].exp_oe);
      check("edges", edge_cnt, C);
      check("pix_data", pix_err, 0);
      edge_cnt  = 0;
      pix_err   = 0;
      shift_row = (shift_row + 1) % R;
      oe_low    = 0;
      step();
      gap = 1;
      check("p_addr", p_addr, vecs[i].exp_addr);
      check("frame_done", frame_done, vecs[i].exp_fd);
      if (vecs[i].drop_en) begin
        check("idle_after_drop", busy, 0);
        idle_viol = 0;
        repeat ($urandom_range(ON + 20, ON + 200)) begin
          step();
          if (busy || !p_oe_n || p_clk || p_lat) idle_viol++;
        end
        check("dark_idle", idle_viol, 0);
      end
    end

    check("lat_overlap", viol, 0);
    check("fd_pulses", fd_cnt, fd_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
